// File: rtl/mem_responder.sv
// Word-addressed local SRAM answering the core's imem (read-only) and dmem (read/write) ports.
// Optional MEM_RESP_STALL_EN adds 0..3 pseudo-random extra cycles to every dmem response.
module mem_responder #(
    parameter logic [31:0] ADDR_BASE    = 32'h1eceb000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          IMEM_LATENCY = 1,
    parameter int          DMEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        err
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   word_reg [2];
    logic [31:0]   addr [2];
    logic [IW-1:0] idx [2];
    logic [15:0]   lat_load [2];
    logic [31:0]   rdata_int [2];
    logic [1:0]    req;
    logic [1:0]    in_range;
    logic [1:0]    accept;
    logic [1:0]    collide;
    logic [1:0]    resp_w;
    logic          dmem_write;
    logic          both_masks;
    logic          err_reg;

    assign addr[0]    = imem_addr;
    assign addr[1]    = dmem_addr;
    assign req[0]     = |imem_rmask;
    assign req[1]     = (|dmem_rmask) | (|dmem_wmask);
    assign dmem_write = |dmem_wmask;
    assign both_masks = (|dmem_rmask) & (|dmem_wmask);
    assign lat_load[0] = 16'(IMEM_LATENCY - 1);

`ifdef MEM_RESP_STALL_EN
    logic [15:0] lfsr_reg;

    // Right-shifting form of x^16+x^14+x^13+x^11+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_reg <= 16'hACE1;
        else
            lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
    end

    assign lat_load[1] = 16'(DMEM_LATENCY - 1) + {14'd0, lfsr_reg[1:0]};
`else
    assign lat_load[1] = 16'(DMEM_LATENCY - 1);
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [31:0] off;
        state_t      state_reg;
        logic [15:0] cnt_reg;
        logic        resp_reg;
        logic        oor_reg;
        logic [31:0] hold_reg;

        assign off          = addr[gi] - ADDR_BASE;
        assign in_range[gi] = (addr[gi] >= ADDR_BASE) && ({32'd0, off} < (64'(DEPTH_WORDS) << 2));
        assign idx[gi]      = off[IW+1:2];
        // The resp cycle (BUSY at count 0) doubles as an IDLE cycle so requests can chain.
        assign accept[gi]   = req[gi] && (state_reg == IDLE || cnt_reg == 16'd0);
        assign collide[gi]  = req[gi] && state_reg == BUSY && cnt_reg != 16'd0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= IDLE;
                cnt_reg   <= 16'd0;
                resp_reg  <= 1'b0;
                oor_reg   <= 1'b0;
                hold_reg  <= 32'd0;
            end else begin
                if (resp_reg)
                    hold_reg <= rdata_int[gi];
                if (accept[gi]) begin
                    state_reg <= BUSY;
                    cnt_reg   <= lat_load[gi];
                    resp_reg  <= (lat_load[gi] == 16'd0);
                    oor_reg   <= !in_range[gi];
                end else if (state_reg == BUSY) begin
                    if (cnt_reg == 16'd0) begin
                        state_reg <= IDLE;
                        resp_reg  <= 1'b0;
                    end else begin
                        cnt_reg  <= cnt_reg - 16'd1;
                        resp_reg <= (cnt_reg == 16'd1);
                    end
                end
            end
        end

        // Live word only in the resp cycle; otherwise replay the last delivered word.
        assign rdata_int[gi] = resp_reg ? (oor_reg ? 32'd0 : word_reg[gi]) : hold_reg;
        assign resp_w[gi]    = resp_reg;
    end

    // Array reads and writes share one edge; non-blocking order gives read-before-write.
    always_ff @(posedge clk) begin
        if (accept[0])
            word_reg[0] <= mem[idx[0]];
        if (accept[1])
            word_reg[1] <= mem[idx[1]];
        if (accept[1] && dmem_write && in_range[1]) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wmask[b])
                    mem[idx[1]][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_reg <= 1'b0;
        else if ((|collide) || (|(accept & ~in_range)) || (accept[1] && both_masks))
            err_reg <= 1'b1;
    end

    assign imem_resp  = resp_w[0];
    assign dmem_resp  = resp_w[1];
    assign imem_rdata = rdata_int[0];
    assign dmem_rdata = rdata_int[1];
    assign err        = err_reg;

endmodule
